tcb_peri_gpio_cdc: RTL and testbench

- Multi-stage flip-flop synchronizer bringing asynchronous GPIO input pins into the clk domain.
- Sits between the GPIO pads and the register/interrupt logic of the TCB GPIO peripheral; its output feeds input-data readback and interrupt detection.
- Optional per-bit enable freezes unused synchronizer bits to save power.

---
 rtl/tcb_peri_gpio_cdc_pkg.sv | 7 +
 rtl/tcb_peri_gpio_sync_bit.sv | 27 ++
 rtl/tcb_peri_gpio_cdc.sv | 37 +++
 tb/tb_tcb_peri_gpio_cdc.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/tcb_peri_gpio_cdc_pkg.sv
// Shared constants for the TCB GPIO input synchronizer.
package tcb_peri_gpio_cdc_pkg;

   // Fewer than two stages gives no MTBF margin against metastability.
   localparam int unsigned CDC_MIN = 2;

endpackage : tcb_peri_gpio_cdc_pkg

// File: rtl/tcb_peri_gpio_sync_bit.sv
// One-bit, CDC-deep synchronizer chain; the enable gates all stages together.
module tcb_peri_gpio_sync_bit #(
   parameter int unsigned CDC = 2
)(
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   input  logic d_i,
   output logic q_o
);

   (* ASYNC_REG = "TRUE" *) logic [CDC-1:0] sync_q;
   logic [CDC-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[CDC-2:0], d_i};
   end

   // A common enable for every stage keeps a frozen chain coherent on resume.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       sync_q <= '0;
      else if (en_i) sync_q <= sync_d;
   end

   assign q_o = sync_q[CDC-1];

endmodule : tcb_peri_gpio_sync_bit

// File: rtl/tcb_peri_gpio_cdc.sv
// GPIO pad input synchronizer: GDW independent CDC-deep chains into the clk domain.
module tcb_peri_gpio_cdc
   import tcb_peri_gpio_cdc_pkg::*;
#(
   parameter int unsigned GDW = 32,
   parameter int unsigned CDC = 2,
   parameter bit          IEN = 1'b0
)(
   input  logic           clk,
   input  logic           rst,
   input  logic [GDW-1:0] gpio_i,
   input  logic [GDW-1:0] gpio_e,
   output logic [GDW-1:0] gpio_r
);

   generate
      if (CDC < CDC_MIN) begin : g_bad_cdc
         $error("tcb_peri_gpio_cdc: CDC=%0d, must be >= %0d", CDC, CDC_MIN);
      end else begin : g_sync
         for (genvar n = 0; n < GDW; n++) begin : g_bit
            logic en;
            assign en = IEN ? gpio_e[n] : 1'b1;

            tcb_peri_gpio_sync_bit #(
               .CDC  (CDC)
            ) u_bit (
               .clk  (clk),
               .rst  (rst),
               .en_i (en),
               .d_i  (gpio_i[n]),
               .q_o  (gpio_r[n])
            );
         end
      end
   endgenerate

endmodule : tcb_peri_gpio_cdc

// File: tb/tb_tcb_peri_gpio_cdc.sv
// Self-checking bench: delay-line scoreboard for ungated instances, vector table and hand sequences.
module tb_tcb_peri_gpio_cdc;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] gi  = '0;
   logic [31:0] ge  = '0;
   logic [31:0] r2, r3, r1;
   logic [7:0]  r8;

   int checks = 0;
   int errors = 0;

   logic [31:0] q2[$];
   logic [31:0] q3[$];
   logic [31:0] q8[$];

   always #5 clk = ~clk;

   tcb_peri_gpio_cdc #(.GDW(32), .CDC(2), .IEN(1'b0)) u_c2 (
      .clk(clk), .rst(rst), .gpio_i(gi), .gpio_e(ge), .gpio_r(r2));
   tcb_peri_gpio_cdc #(.GDW(32), .CDC(3), .IEN(1'b0)) u_c3 (
      .clk(clk), .rst(rst), .gpio_i(gi), .gpio_e(ge), .gpio_r(r3));
   tcb_peri_gpio_cdc #(.GDW(32), .CDC(2), .IEN(1'b1)) u_e1 (
      .clk(clk), .rst(rst), .gpio_i(gi), .gpio_e(ge), .gpio_r(r1));
   tcb_peri_gpio_cdc #(.GDW(8),  .CDC(2), .IEN(1'b0)) u_w8 (
      .clk(clk), .rst(rst), .gpio_i(gi[7:0]), .gpio_e(ge[7:0]), .gpio_r(r8));

   typedef struct {
      logic [31:0] gi;
      logic [31:0] ge;
      logic [31:0] exp_ungated;
      logic [31:0] exp_gated;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected value for an ungated chain is the input applied CDC edges earlier.
   task automatic sb_init();
      q2 = {}; q3 = {}; q8 = {};
      q2.push_back('0);
      q3.push_back('0); q3.push_back('0);
      q8.push_back('0);
   endtask

   // Drive at a falling edge, push expectation, advance one edge, then pop and compare.
   task automatic step(input logic [31:0] v, input logic [31:0] e);
      gi = v;
      ge = e;
      q2.push_back(v);
      q3.push_back(v);
      q8.push_back({24'h0, v[7:0]});
      @(negedge clk);
      chk("sb_cdc2", r2, q2.pop_front());
      chk("sb_cdc3", r3, q3.pop_front());
      chk("sb_gdw8", {24'h0, r8}, q8.pop_front());
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_c2"}, r2, '0);
      chk({name, "_c3"}, r3, '0);
      chk({name, "_e1"}, r1, '0);
      chk({name, "_w8"}, {24'h0, r8}, '0);
   endtask

   initial begin
      vecs[0] = '{32'h1234_5678, 32'hFFFF_FFFF, 32'h1234_5678, 32'h1234_5678};
      vecs[1] = '{32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, 32'h1234_5678};
      vecs[2] = '{32'hFFFF_FFFF, 32'h0000_FFFF, 32'hFFFF_FFFF, 32'h1234_FFFF};
      vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      vecs[4] = '{32'h0000_00F0, 32'hFFFF_FFFF, 32'h0000_00F0, 32'h0000_00F0};
      vecs[5] = '{32'hA5A5_A5A5, 32'h0000_0000, 32'hA5A5_A5A5, 32'h0000_00F0};
      vecs[6] = '{32'h0000_0000, 32'h0000_FFFF, 32'h0000_0000, 32'h0000_0000};

      // Reset held with all pins high.
      gi = 32'hFFFF_FFFF;
      ge = 32'hFFFF_FFFF;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk_all_zero("reset_hold");
      end
      gi = '0;
      @(negedge clk);
      rst = 1'b0;
      sb_init();

      // First-transaction latency on both chain depths.
      step(32'h1234_5678, 32'hFFFF_FFFF);
      chk("lat_c2_E", r2, 32'h0);
      step(32'h1234_5678, 32'hFFFF_FFFF);
      chk("lat_c2_E1", r2, 32'h1234_5678);
      chk("lat_c3_E1", r3, 32'h0);
      step(32'h1234_5678, 32'hFFFF_FFFF);
      chk("lat_c3_E2", r3, 32'h1234_5678);

      // Settle-based vector table.
      for (int v = 0; v < 7; v++) begin
         for (int h = 0; h < 4; h++) step(vecs[v].gi, vecs[v].ge);
         chk($sformatf("vec%0d_c2", v), r2, vecs[v].exp_ungated);
         chk($sformatf("vec%0d_c3", v), r3, vecs[v].exp_ungated);
         chk($sformatf("vec%0d_w8", v), {24'h0, r8}, {24'h0, vecs[v].exp_ungated[7:0]});
         chk($sformatf("vec%0d_e1", v), r1, vecs[v].exp_gated);
      end

      // Gated chain: half enabled, then full re-enable.
      step(32'hFFFF_FFFF, 32'h0000_FFFF);
      chk("gate_e1_edge1", r1, 32'h0000_0000);
      step(32'hFFFF_FFFF, 32'h0000_FFFF);
      chk("gate_e1_edge2", r1, 32'h0000_FFFF);
      for (int i = 0; i < 3; i++) begin
         step(32'hFFFF_FFFF, 32'h0000_FFFF);
         chk("gate_e1_stay", r1, 32'h0000_FFFF);
      end
      step(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      chk("reen_e1_edge1", r1, 32'h0000_FFFF);
      step(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      chk("reen_e1_edge2", r1, 32'hFFFF_FFFF);

      // Frozen chain ignores pin activity.
      step(32'h0000_00F0, 32'hFFFF_FFFF);
      step(32'h0000_00F0, 32'hFFFF_FFFF);
      chk("hold_e1_pre", r1, 32'h0000_00F0);
      for (int i = 0; i < 10; i++) begin
         step($urandom, 32'h0);
         chk("hold_e1", r1, 32'h0000_00F0);
      end

      // Single-cycle pulse on bit 3 of the narrow instance.
      for (int i = 0; i < 3; i++) step(32'h0, 32'hFFFF_FFFF);
      step(32'h8, 32'hFFFF_FFFF);
      step(32'h0, 32'hFFFF_FFFF);
      chk("pulse_w8_hi", {24'h0, r8}, 32'h8);
      step(32'h0, 32'hFFFF_FFFF);
      chk("pulse_w8_lo", {24'h0, r8}, 32'h0);

      // Asynchronous reset mid-cycle.
      for (int i = 0; i < 3; i++) step(32'hA5A5_A5A5, 32'hFFFF_FFFF);
      chk("pre_rst_c2", r2, 32'hA5A5_A5A5);
      chk("pre_rst_e1", r1, 32'hA5A5_A5A5);
      #2;
      ge  = 32'h0;
      rst = 1'b1;
      #1;
      chk_all_zero("async_rst");
      gi = '0;
      @(negedge clk);
      chk_all_zero("rst_held");
      rst = 1'b0;
      sb_init();
      for (int i = 0; i < 3; i++) step(32'h0, 32'hFFFF_FFFF);
      step(32'h5A5A_5A5A, 32'hFFFF_FFFF);
      step(32'h5A5A_5A5A, 32'hFFFF_FFFF);
      chk("post_rst_c2", r2, 32'h5A5A_5A5A);
      chk("post_rst_e1", r1, 32'h5A5A_5A5A);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_tcb_peri_gpio_cdc
